// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// IRQ_CTRL_ROTATE_EN selects round-robin instead of fixed priority.
package irq_ctrl_pkg;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_e;

  localparam int NSRC_MAX = 8;
  localparam int VW       = 3;

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side request/acknowledge bundle of the interrupt controller.
// Shared by irq_ctrl (slave) and its driver (master).
interface irq_ctrl_if #(
  parameter int NSRC = 8
);
  import irq_ctrl_pkg::*;

  logic [NSRC-1:0] irq_req;
  logic [NSRC-1:0] mask;
  logic            ack;
  logic            ovr_clr;
  logic            intr;
  logic [VW-1:0]   vect;
  logic            busy;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] overrun;

  modport master (
    output irq_req, mask, ack, ovr_clr,
    input  intr, vect, busy, pending, overrun
  );

  modport slave (
    input  irq_req, mask, ack, ovr_clr,
    output intr, vect, busy, pending, overrun
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Find-first-set over N request bits, searching upward from ptr_i
// and wrapping at N; idx_o is meaningful only when vld_o is 1.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]  req_i,
  input  logic [VW-1:0] ptr_i,
  output logic [VW-1:0] idx_o,
  output logic          vld_o
);

  logic [NSRC_MAX-1:0] req_x;
  logic [VW-1:0]       idx;
  logic [VW-1:0]       cur;
  logic                vld;

  assign req_x = NSRC_MAX'(req_i);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    cur = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ptr_i) + k >= N) begin
        cur = VW'(int'(ptr_i) + k - N);
      end else begin
        cur = VW'(int'(ptr_i) + k);
      end
      if (!vld && req_x[cur]) begin
        vld = 1'b1;
        idx = cur;
      end
    end
  end

  assign idx_o = idx;
  assign vld_o = vld;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches masked request pulses, dispatches one at a
// time as an intr toggle, waits for ack. IRQ_CTRL_ROTATE_EN: round-robin.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input logic        clock,
  input logic        reset,
  irq_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic            intr_q, intr_d;
  logic [VW-1:0]   vect_q, vect_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ovr_q, ovr_d;

  logic [NSRC-1:0] req_v;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] win_oh;
  logic [VW-1:0]   ptr;
  logic [VW-1:0]   win;
  logic            win_vld;
  logic            disp;

  assign req_v = bus.irq_req & bus.mask;
  assign cand  = pend_q & bus.mask;

  irq_prio_enc #(
    .N (NSRC)
  ) u_enc (
    .req_i (cand),
    .ptr_i (ptr),
    .idx_o (win),
    .vld_o (win_vld)
  );

`ifdef IRQ_CTRL_ROTATE_EN
  logic [VW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (disp) begin
      ptr_d = (win == VW'(NSRC - 1)) ? '0 : win + VW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    vect_d  = vect_q;
    disp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          disp    = 1'b1;
          state_d = WAIT_ACK;
          intr_d  = ~intr_q;
          vect_d  = win;
        end
      end
      WAIT_ACK: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A request landing on the winner's dispatch edge re-arms it cleanly.
  assign win_oh = disp ? (NSRC'(1) << win) : '0;
  assign pend_d = (cand & ~win_oh) | req_v;
  assign ovr_d  = (bus.ovr_clr ? '0 : ovr_q)
                | (req_v & pend_q & ~win_oh);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      intr_q  <= 1'b0;
      vect_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      vect_q  <= vect_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.intr    = intr_q;
  assign bus.vect    = vect_q;
  assign bus.busy    = (state_q == WAIT_ACK);
  assign bus.pending = pend_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; expected vectors are queued as stimulus
// is driven and popped whenever intr toggles.
module tb_irq_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  irq_ctrl_if #(.NSRC(8)) b ();

  irq_ctrl #(
    .NSRC (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  always #5 clock = ~clock;

  int   n_chk = 0;
  int   n_fail = 0;
  int   ntog = 0;
  int   t0;
  logic intr_prev = 1'b0;
  int   exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    if (r) begin
      intr_prev = b.intr;
    end else if (b.intr !== intr_prev) begin
      intr_prev = b.intr;
      ntog++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_toggle observed vect=%0d expected none",
               b.vect);
      end else begin
        chk("vect", 32'(b.vect), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    b.irq_req = '0;
    b.ack     = 1'b0;
    b.ovr_clr = 1'b0;
    b.mask    = 8'hFF;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_toggle(input string tag);
    int s;
    s = ntog;
    for (int k = 0; k < 6; k++) begin
      if (ntog == s) step();
    end
    chk(tag, 32'(ntog - s), 32'd1);
  endtask

  task automatic ack_pulse();
    b.ack = 1'b1;
    step();
    b.ack = 1'b0;
  endtask

  int rr[4];

  initial begin
    b.irq_req = '0;
    b.mask    = 8'hFF;
    b.ack     = 1'b0;
    b.ovr_clr = 1'b0;
    do_reset();
    chk("rst_intr", 32'(b.intr), 32'd0);
    chk("rst_vect", 32'(b.vect), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_pend", 32'(b.pending), 32'h00);
    chk("rst_ovr", 32'(b.overrun), 32'h00);

    // single request, one-edge latency
    b.irq_req = 8'h02;
    exp_q.push_back(1);
    step();
    b.irq_req = 8'h00;
    chk("t1_pend_set", 32'(b.pending), 32'h02);
    chk("t1_intr_pre", 32'(b.intr), 32'd0);
    step();
    chk("t1_intr", 32'(b.intr), 32'd1);
    chk("t1_busy", 32'(b.busy), 32'd1);
    chk("t1_pend_clr", 32'(b.pending), 32'h00);
    ack_pulse();
    chk("t1_ack_busy", 32'(b.busy), 32'd0);

    // two simultaneous requests, priority then ack
    do_reset();
    b.irq_req = 8'h06;
    exp_q.push_back(1);
    exp_q.push_back(2);
    step();
    b.irq_req = 8'h00;
    step();
    chk("t2_pend", 32'(b.pending), 32'h04);
    t0 = ntog;
    step();
    chk("t2_hold_vect", 32'(b.vect), 32'd1);
    chk("t2_hold_tog", 32'(ntog - t0), 32'd0);
    ack_pulse();
    chk("t2_ack_notog", 32'(ntog - t0), 32'd0);
    step();
    chk("t2_second_tog", 32'(ntog - t0), 32'd1);
    ack_pulse();

    // overrun while busy, then clear
    b.irq_req = 8'h01;
    exp_q.push_back(0);
    step();
    b.irq_req = 8'h04;
    step();
    chk("t3_busy", 32'(b.busy), 32'd1);
    step();
    step();
    b.irq_req = 8'h00;
    chk("t3_pend", 32'(b.pending), 32'h04);
    chk("t3_ovr", 32'(b.overrun), 32'h04);
    b.ovr_clr = 1'b1;
    step();
    b.ovr_clr = 1'b0;
    chk("t3_ovr_clr", 32'(b.overrun), 32'h00);
    b.ovr_clr = 1'b1;
    b.irq_req = 8'h04;
    step();
    b.ovr_clr = 1'b0;
    b.irq_req = 8'h00;
    chk("t3_ovr_wins", 32'(b.overrun), 32'h04);
    b.ovr_clr = 1'b1;
    step();
    b.ovr_clr = 1'b0;
    exp_q.push_back(2);
    ack_pulse();
    wait_toggle("t3_dispatch");
    ack_pulse();

    // masked request discarded; pending dropped when masked
    t0 = ntog;
    b.mask    = 8'hFD;
    b.irq_req = 8'h02;
    step();
    b.irq_req = 8'h00;
    chk("t4_masked_pend", 32'(b.pending), 32'h00);
    step();
    step();
    b.mask    = 8'hFF;
    b.irq_req = 8'h08;
    step();
    b.irq_req = 8'h00;
    b.mask    = 8'hF7;
    chk("t4_pend3", 32'(b.pending), 32'h08);
    step();
    chk("t4_pend3_clr", 32'(b.pending), 32'h00);
    step();
    b.mask = 8'hFF;
    chk("t4_no_tog", 32'(ntog - t0), 32'd0);
    chk("t4_idle", 32'(b.busy), 32'd0);

    // reset during service
    b.irq_req = 8'h01;
    exp_q.push_back(0);
    step();
    b.irq_req = 8'h04;
    step();
    b.irq_req = 8'h00;
    chk("t5_pend", 32'(b.pending), 32'h04);
    chk("t5_busy", 32'(b.busy), 32'd1);
    reset = 1'b1;
    step();
    chk("t5_intr", 32'(b.intr), 32'd0);
    chk("t5_vect", 32'(b.vect), 32'd0);
    chk("t5_rbusy", 32'(b.busy), 32'd0);
    chk("t5_rpend", 32'(b.pending), 32'h00);
    chk("t5_rovr", 32'(b.overrun), 32'h00);
    reset = 1'b0;
    t0 = ntog;
    for (int k = 0; k < 4; k++) step();
    chk("t5_no_tog", 32'(ntog - t0), 32'd0);

    // continuous requests from 1 and 2
`ifdef IRQ_CTRL_ROTATE_EN
    rr = '{1, 2, 1, 2};
`else
    rr = '{1, 1, 1, 1};
`endif
    do_reset();
    b.irq_req = 8'h06;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rr[i]);
      wait_toggle("t6_dispatch");
      ack_pulse();
    end
    b.irq_req = 8'h00;
    do_reset();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
